// File: rtl/lv_wdg_tmr_pkg.sv
// Shared low-voltage parameters for the watchdog timer.
// Holds the watchdog state encoding, the tick width and the default prescaler divisor.
package lv_wdg_tmr_pkg;

    // Watchdog state encoding. It is also visible on o_wdg_cur_st.
    typedef enum logic [1:0] {
        WDG_IDLE   = 2'd0,
        WDG_CLOSED = 2'd1,
        WDG_OPEN   = 2'd2,
        WDG_ERR    = 2'd3
    } wdg_st_e;

    localparam int LV_WDG_TICK_W      = 8;
    localparam int LV_PRESCL_DIV_DFLT = 1000;

endpackage

// File: rtl/lv_wdg_tmr_if.sv
// Control, configuration and status bundle of the low-voltage watchdog timer.
// The master modport is the controller side. The slave modport is the watchdog side.
interface lv_wdg_tmr_if
    import lv_wdg_tmr_pkg::*;
#(
    parameter int WDG_TICK_W = LV_WDG_TICK_W
);
    logic                  i_wdg_scan_en;
    logic                  i_wdg_kick;
    logic [WDG_TICK_W-1:0] i_reg_wdg_tmo_val;
    logic [WDG_TICK_W-1:0] i_reg_wdg_win_val;
    logic                  i_reg_wdg_err_clr;
    logic                  o_wdg_tmo_err;
    logic                  o_wdg_early_err;
    logic [1:0]            o_wdg_cur_st;
    logic [WDG_TICK_W-1:0] o_wdg_tick_cnt;

    modport master (
        output i_wdg_scan_en, i_wdg_kick, i_reg_wdg_tmo_val, i_reg_wdg_win_val, i_reg_wdg_err_clr,
        input  o_wdg_tmo_err, o_wdg_early_err, o_wdg_cur_st, o_wdg_tick_cnt
    );

    modport slave (
        input  i_wdg_scan_en, i_wdg_kick, i_reg_wdg_tmo_val, i_reg_wdg_win_val, i_reg_wdg_err_clr,
        output o_wdg_tmo_err, o_wdg_early_err, o_wdg_cur_st, o_wdg_tick_cnt
    );
endinterface

// File: rtl/lv_wdg_prescl.sv
// Watchdog prescaler: divides i_clk down to a one-cycle tick every PRESCL_DIV cycles.
// It counts only while enabled and sits at zero otherwise.
module lv_wdg_prescl #(
    parameter int PRESCL_DIV = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CNT_W = $clog2(PRESCL_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCL_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_tick = i_en && (cnt_q == CNT_LAST);

    // Next count: a clear or a disable forces zero; otherwise wrap at the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr || !i_en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/lv_wdg_tmr.sv
// Low-voltage windowed watchdog.
// The closed window rejects early kicks, the open window accepts a refresh, and a
// missing refresh raises a timeout. Both error flags are sticky until cleared.
module lv_wdg_tmr
    import lv_wdg_tmr_pkg::*;
#(
    parameter int PRESCL_DIV = LV_PRESCL_DIV_DFLT,
    parameter int WDG_TICK_W = LV_WDG_TICK_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    lv_wdg_tmr_if.slave   wdg
);
    wdg_st_e               state_q, state_d;
    logic [WDG_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic                  tmo_err_q, tmo_err_d;
    logic                  early_err_q, early_err_d;

    logic prescl_en;
    logic prescl_clr;
    logic tick;
    logic restart;
    logic set_tmo;
    logic set_early;
    logic tmo_hit;

    assign prescl_en  = (state_q == WDG_CLOSED) || (state_q == WDG_OPEN);
    assign prescl_clr = !wdg.i_wdg_scan_en || restart;
    assign tmo_hit    = (wdg.i_reg_wdg_tmo_val != '0) && (tick_cnt_q >= wdg.i_reg_wdg_tmo_val);

    lv_wdg_prescl #(
        .PRESCL_DIV (PRESCL_DIV)
    ) u_prescl (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (prescl_en),
        .i_clr   (prescl_clr),
        .o_tick  (tick)
    );

    // Next-state decision. Disable beats everything, kick beats timeout, and timeout beats opening the window.
    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        set_tmo   = 1'b0;
        set_early = 1'b0;
        if (!wdg.i_wdg_scan_en) begin
            state_d = WDG_IDLE;
        end else begin
            case (state_q)
                WDG_IDLE: restart = 1'b1;
                WDG_CLOSED: begin
                    if (wdg.i_wdg_kick) begin
                        state_d   = WDG_ERR;
                        set_early = 1'b1;
                    end else if (tmo_hit) begin
                        state_d = WDG_ERR;
                        set_tmo = 1'b1;
                    end else if (tick_cnt_q >= wdg.i_reg_wdg_win_val) begin
                        state_d = WDG_OPEN;
                    end
                end
                WDG_OPEN: begin
                    if (wdg.i_wdg_kick) begin
                        restart = 1'b1;
                    end else if (tmo_hit) begin
                        state_d = WDG_ERR;
                        set_tmo = 1'b1;
                    end
                end
                WDG_ERR: restart = wdg.i_reg_wdg_err_clr;
                default: state_d = WDG_IDLE;
            endcase
            if (restart) begin
                state_d = (wdg.i_reg_wdg_win_val != '0) ? WDG_CLOSED : WDG_OPEN;
            end
        end
    end

    // Tick counter and sticky flags. A set in the same cycle as a clear keeps the flag.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (prescl_clr) begin
            tick_cnt_d = '0;
        end else if (tick && (tick_cnt_q != '1)) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
        tmo_err_d   = set_tmo   || (tmo_err_q   && !wdg.i_reg_wdg_err_clr);
        early_err_d = set_early || (early_err_q && !wdg.i_reg_wdg_err_clr);
    end

    // State, counter and flag registers. Every output comes straight from these.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= WDG_IDLE;
            tick_cnt_q  <= '0;
            tmo_err_q   <= 1'b0;
            early_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            tmo_err_q   <= tmo_err_d;
            early_err_q <= early_err_d;
        end
    end

    assign wdg.o_wdg_cur_st    = state_q;
    assign wdg.o_wdg_tick_cnt  = tick_cnt_q;
    assign wdg.o_wdg_tmo_err   = tmo_err_q;
    assign wdg.o_wdg_early_err = early_err_q;
endmodule

// File: tb/tb_lv_wdg_tmr.sv
// Testbench for lv_wdg_tmr.
// It runs the directed scenarios first, then randomized traffic compared against a behavioural model.
module tb_lv_wdg_tmr;
    import lv_wdg_tmr_pkg::*;

    localparam int DIV   = 4;
    localparam int TW    = 8;
    localparam int TMAX  = 255;
    localparam int LIMIT = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lv_wdg_tmr_if #(.WDG_TICK_W(TW)) wif ();

    lv_wdg_tmr #(
        .PRESCL_DIV (DIV),
        .WDG_TICK_W (TW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wdg     (wif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: elapsed cycles since the last restart while counting.
    // In error state the tick count is frozen.
    wdg_st_e m_mode;
    int      m_elapsed;
    int      m_frozen;
    bit      m_tmo;
    bit      m_early;

    function automatic int sat(input int v);
        return (v > TMAX) ? TMAX : v;
    endfunction

    function automatic int m_tc();
        if (m_mode == WDG_CLOSED || m_mode == WDG_OPEN) return sat(m_elapsed / DIV);
        return m_frozen;
    endfunction

    task automatic model_reset();
        m_mode = WDG_IDLE; m_elapsed = 0; m_frozen = 0; m_tmo = 0; m_early = 0;
    endtask

    task automatic model_step();
        int tc, win, tmo;
        bit en, kick, clr, rs, s_tmo, s_early, to_err;
        tc = m_tc();
        en = wif.i_wdg_scan_en; kick = wif.i_wdg_kick; clr = wif.i_reg_wdg_err_clr;
        win = int'(wif.i_reg_wdg_win_val); tmo = int'(wif.i_reg_wdg_tmo_val);
        rs = 0; s_tmo = 0; s_early = 0; to_err = 0;
        if (!en) begin
            m_mode = WDG_IDLE; m_elapsed = 0; m_frozen = 0;
        end else begin
            if (m_mode == WDG_IDLE) rs = 1;
            else if (m_mode == WDG_ERR) rs = clr;
            else if (kick && m_mode == WDG_OPEN) rs = 1;
            else if (kick) begin s_early = 1; to_err = 1; end
            else if (tmo != 0 && tc >= tmo) begin s_tmo = 1; to_err = 1; end
            else begin
                if (m_mode == WDG_CLOSED && tc >= win) m_mode = WDG_OPEN;
                m_elapsed++;
            end
            if (to_err) begin
                m_frozen = sat((m_elapsed + 1) / DIV);
                m_mode = WDG_ERR;
            end
            if (rs) begin
                m_elapsed = 0; m_frozen = 0;
                m_mode = (win != 0) ? WDG_CLOSED : WDG_OPEN;
            end
        end
        m_tmo   = s_tmo   || (m_tmo   && !clr);
        m_early = s_early || (m_early && !clr);
    endtask

    // One clock: the model advances on the edge, and the bench returns on the falling edge.
    task automatic clk_step();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        wif.i_wdg_scan_en = 0; wif.i_wdg_kick = 0; wif.i_reg_wdg_err_clr = 0;
        wif.i_reg_wdg_tmo_val = 0; wif.i_reg_wdg_win_val = 0;
        clk_step(); clk_step();
        checks++;
        if (wif.o_wdg_cur_st !== WDG_IDLE || wif.o_wdg_tick_cnt !== 0 ||
            wif.o_wdg_tmo_err !== 0 || wif.o_wdg_early_err !== 0) begin
            errors++;
            $display("FAIL reset_state got st=%0d cnt=%0d tmo=%0b early=%0b need 0/0/0/0",
                     wif.o_wdg_cur_st, wif.o_wdg_tick_cnt, wif.o_wdg_tmo_err, wif.o_wdg_early_err);
        end
        rst_n = 1; clk_step(); clk_step();
        checks++;
        if (wif.o_wdg_cur_st !== WDG_IDLE) begin
            errors++; $display("FAIL idle_when_disabled got st=%0d need %0d", wif.o_wdg_cur_st, WDG_IDLE);
        end
    endtask

    task automatic test_kick_open();
        int n;
        wif.i_reg_wdg_win_val = 2; wif.i_reg_wdg_tmo_val = 5; wif.i_wdg_scan_en = 1;
        clk_step();
        checks++;
        if (wif.o_wdg_cur_st !== WDG_CLOSED || wif.o_wdg_tick_cnt !== 0) begin
            errors++; $display("FAIL s1_start got st=%0d cnt=%0d need 1/0", wif.o_wdg_cur_st, wif.o_wdg_tick_cnt);
        end
        n = 0;
        while (wif.o_wdg_tick_cnt !== 3 && n < LIMIT) begin clk_step(); n++; end
        checks++;
        if (n >= LIMIT || wif.o_wdg_cur_st !== WDG_OPEN) begin
            errors++; $display("FAIL s1_open got st=%0d cnt=%0d need st=2 cnt=3", wif.o_wdg_cur_st, wif.o_wdg_tick_cnt);
        end
        wif.i_wdg_kick = 1; clk_step(); wif.i_wdg_kick = 0;
        checks++;
        if (wif.o_wdg_cur_st !== WDG_CLOSED || wif.o_wdg_tick_cnt !== 0 ||
            wif.o_wdg_tmo_err !== 0 || wif.o_wdg_early_err !== 0) begin
            errors++;
            $display("FAIL s1_restart got st=%0d cnt=%0d tmo=%0b early=%0b need 1/0/0/0",
                     wif.o_wdg_cur_st, wif.o_wdg_tick_cnt, wif.o_wdg_tmo_err, wif.o_wdg_early_err);
        end
    endtask

    task automatic test_early_kick();
        int n;
        n = 0;
        while (wif.o_wdg_tick_cnt !== 1 && n < LIMIT) begin clk_step(); n++; end
        checks++;
        if (n >= LIMIT || wif.o_wdg_cur_st !== WDG_CLOSED) begin
            errors++; $display("FAIL s2_closed got st=%0d cnt=%0d need st=1 cnt=1", wif.o_wdg_cur_st, wif.o_wdg_tick_cnt);
        end
        wif.i_wdg_kick = 1; clk_step(); wif.i_wdg_kick = 0;
        checks++;
        if (wif.o_wdg_cur_st !== WDG_ERR || wif.o_wdg_early_err !== 1 || wif.o_wdg_tmo_err !== 0) begin
            errors++;
            $display("FAIL s2_early got st=%0d early=%0b tmo=%0b need 3/1/0",
                     wif.o_wdg_cur_st, wif.o_wdg_early_err, wif.o_wdg_tmo_err);
        end
        wif.i_wdg_kick = 1; clk_step(); wif.i_wdg_kick = 0;
        checks++;
        if (wif.o_wdg_cur_st !== WDG_ERR) begin
            errors++; $display("FAIL s2_err_ignores_kick got st=%0d need 3", wif.o_wdg_cur_st);
        end
        wif.i_reg_wdg_err_clr = 1; clk_step(); wif.i_reg_wdg_err_clr = 0;
        checks++;
        if (wif.o_wdg_cur_st !== WDG_CLOSED || wif.o_wdg_early_err !== 0 || wif.o_wdg_tick_cnt !== 0) begin
            errors++;
            $display("FAIL s2_clear got st=%0d early=%0b cnt=%0d need 1/0/0",
                     wif.o_wdg_cur_st, wif.o_wdg_early_err, wif.o_wdg_tick_cnt);
        end
    endtask

    task automatic test_timeout();
        int n;
        int last_cnt;
        wif.i_wdg_scan_en = 0; clk_step();
        checks++;
        if (wif.o_wdg_cur_st !== WDG_IDLE || wif.o_wdg_tick_cnt !== 0) begin
            errors++; $display("FAIL s3_idle got st=%0d cnt=%0d need 0/0", wif.o_wdg_cur_st, wif.o_wdg_tick_cnt);
        end
        wif.i_reg_wdg_win_val = 0; wif.i_reg_wdg_tmo_val = 3; wif.i_wdg_scan_en = 1;
        clk_step();
        n = 0; last_cnt = -1;
        while (wif.o_wdg_cur_st === WDG_OPEN && n < LIMIT) begin
            last_cnt = int'(wif.o_wdg_tick_cnt); clk_step(); n++;
        end
        checks++;
        if (wif.o_wdg_cur_st !== WDG_ERR || wif.o_wdg_tmo_err !== 1 ||
            wif.o_wdg_early_err !== 0 || last_cnt != 3) begin
            errors++;
            $display("FAIL s3_timeout got st=%0d tmo=%0b early=%0b last_open_cnt=%0d need 3/1/0/3",
                     wif.o_wdg_cur_st, wif.o_wdg_tmo_err, wif.o_wdg_early_err, last_cnt);
        end
        wif.i_reg_wdg_err_clr = 1; clk_step(); wif.i_reg_wdg_err_clr = 0;
        checks++;
        if (wif.o_wdg_cur_st !== WDG_OPEN || wif.o_wdg_tick_cnt !== 0 ||
            wif.o_wdg_tmo_err !== 0 || wif.o_wdg_early_err !== 0) begin
            errors++;
            $display("FAIL s3_clear got st=%0d cnt=%0d tmo=%0b early=%0b need 2/0/0/0",
                     wif.o_wdg_cur_st, wif.o_wdg_tick_cnt, wif.o_wdg_tmo_err, wif.o_wdg_early_err);
        end
    endtask

    task automatic test_kick_at_tmo();
        int n;
        wif.i_reg_wdg_tmo_val = 4; wif.i_reg_wdg_win_val = 2;
        n = 0;
        while (wif.o_wdg_tick_cnt !== 4 && n < LIMIT) begin clk_step(); n++; end
        checks++;
        if (n >= LIMIT || wif.o_wdg_cur_st !== WDG_OPEN) begin
            errors++; $display("FAIL s4_reach got st=%0d cnt=%0d need st=2 cnt=4", wif.o_wdg_cur_st, wif.o_wdg_tick_cnt);
        end
        wif.i_wdg_kick = 1; clk_step(); wif.i_wdg_kick = 0;
        clk_step();
        checks++;
        if (wif.o_wdg_cur_st !== WDG_CLOSED || wif.o_wdg_tick_cnt !== 0 || wif.o_wdg_tmo_err !== 0) begin
            errors++;
            $display("FAIL s4_kick_wins got st=%0d cnt=%0d tmo=%0b need 1/0/0",
                     wif.o_wdg_cur_st, wif.o_wdg_tick_cnt, wif.o_wdg_tmo_err);
        end
    endtask

    task automatic test_disable_kick();
        int n;
        wif.i_reg_wdg_win_val = 0; wif.i_reg_wdg_tmo_val = 1;
        n = 0;
        while (wif.o_wdg_tmo_err !== 1 && n < LIMIT) begin clk_step(); n++; end
        wif.i_reg_wdg_tmo_val = 0;
        wif.i_wdg_scan_en = 0; clk_step();
        wif.i_wdg_scan_en = 1; clk_step();
        checks++;
        if (n >= LIMIT || wif.o_wdg_cur_st !== WDG_OPEN || wif.o_wdg_tmo_err !== 1) begin
            errors++; $display("FAIL s5_setup got st=%0d tmo=%0b need 2/1", wif.o_wdg_cur_st, wif.o_wdg_tmo_err);
        end
        repeat (5) clk_step();
        wif.i_wdg_scan_en = 0; wif.i_wdg_kick = 1; clk_step(); wif.i_wdg_kick = 0;
        checks++;
        if (wif.o_wdg_cur_st !== WDG_IDLE || wif.o_wdg_tick_cnt !== 0 ||
            wif.o_wdg_tmo_err !== 1 || wif.o_wdg_early_err !== 0) begin
            errors++;
            $display("FAIL s5_disable got st=%0d cnt=%0d tmo=%0b early=%0b need 0/0/1/0",
                     wif.o_wdg_cur_st, wif.o_wdg_tick_cnt, wif.o_wdg_tmo_err, wif.o_wdg_early_err);
        end
    endtask

    task automatic test_async_reset();
        int n;
        wif.i_wdg_scan_en = 1; clk_step();
        n = 0;
        while (wif.o_wdg_tick_cnt !== 3 && n < LIMIT) begin clk_step(); n++; end
        #2 rst_n = 0;
        #1;
        checks++;
        if (n >= LIMIT || wif.o_wdg_cur_st !== WDG_IDLE || wif.o_wdg_tick_cnt !== 0 ||
            wif.o_wdg_tmo_err !== 0 || wif.o_wdg_early_err !== 0) begin
            errors++;
            $display("FAIL s6_async got st=%0d cnt=%0d tmo=%0b early=%0b need 0/0/0/0",
                     wif.o_wdg_cur_st, wif.o_wdg_tick_cnt, wif.o_wdg_tmo_err, wif.o_wdg_early_err);
        end
        model_reset();
        clk_step();
        rst_n = 1; clk_step();
        checks++;
        if (wif.o_wdg_cur_st !== WDG_OPEN || wif.o_wdg_tick_cnt !== 0 || wif.o_wdg_tmo_err !== 0) begin
            errors++;
            $display("FAIL s6_release got st=%0d cnt=%0d tmo=%0b need 2/0/0",
                     wif.o_wdg_cur_st, wif.o_wdg_tick_cnt, wif.o_wdg_tmo_err);
        end
    endtask

    task automatic test_win_ge_tmo();
        int n;
        wif.i_reg_wdg_win_val = 5; wif.i_reg_wdg_tmo_val = 3;
        wif.i_wdg_scan_en = 0; clk_step();
        wif.i_wdg_scan_en = 1; clk_step();
        n = 0;
        while (wif.o_wdg_cur_st === WDG_CLOSED && n < LIMIT) begin clk_step(); n++; end
        checks++;
        if (wif.o_wdg_cur_st !== WDG_ERR || wif.o_wdg_tmo_err !== 1 || wif.o_wdg_early_err !== 0) begin
            errors++;
            $display("FAIL win_ge_tmo got st=%0d tmo=%0b early=%0b need 3/1/0",
                     wif.o_wdg_cur_st, wif.o_wdg_tmo_err, wif.o_wdg_early_err);
        end
        wif.i_reg_wdg_err_clr = 1; clk_step(); wif.i_reg_wdg_err_clr = 0;
    endtask

    task automatic test_saturation();
        wif.i_reg_wdg_win_val = 0; wif.i_reg_wdg_tmo_val = 0;
        wif.i_wdg_scan_en = 0; clk_step();
        wif.i_wdg_scan_en = 1; clk_step();
        repeat ((TMAX + 4) * DIV) clk_step();
        checks++;
        if (wif.o_wdg_cur_st !== WDG_OPEN || wif.o_wdg_tick_cnt !== TW'(TMAX)) begin
            errors++; $display("FAIL saturate got st=%0d cnt=%0d need 2/%0d", wif.o_wdg_cur_st, wif.o_wdg_tick_cnt, TMAX);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            wif.i_wdg_scan_en     = ($urandom_range(0, 99) < 97);
            wif.i_wdg_kick        = ($urandom_range(0, 99) < 6);
            wif.i_reg_wdg_err_clr = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 2) wif.i_reg_wdg_win_val = TW'($urandom_range(0, 6));
            if ($urandom_range(0, 99) < 2) wif.i_reg_wdg_tmo_val = TW'($urandom_range(0, 7));
            if ($urandom_range(0, 999) < 3) begin
                rst_n = 0; clk_step(); rst_n = 1;
            end
            clk_step();
            checks++;
            if (wif.o_wdg_cur_st !== m_mode || wif.o_wdg_tick_cnt !== TW'(m_tc()) ||
                wif.o_wdg_tmo_err !== m_tmo || wif.o_wdg_early_err !== m_early) begin
                errors++;
                $display("FAIL rand_cycle_%0d got st=%0d cnt=%0d tmo=%0b early=%0b need %0d/%0d/%0b/%0b",
                         i, wif.o_wdg_cur_st, wif.o_wdg_tick_cnt, wif.o_wdg_tmo_err, wif.o_wdg_early_err,
                         m_mode, m_tc(), m_tmo, m_early);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_kick_open();
        test_early_kick();
        test_timeout();
        test_kick_at_tmo();
        test_disable_kick();
        test_async_reset();
        test_win_ge_tmo();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lv_wdg_tmr.md
LV_WDG_TMR -- requirements
Module: lv_wdg_tmr

Interface
REQ-001 Parameter PRESCL_DIV, default 1000: i_clk cycles per watchdog tick, legal range 2..65535.
REQ-002 Parameter WDG_TICK_W, default 8: tick counter and window value width.
REQ-003 i_clk  in  1  single clock for the whole block.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_wdg_scan_en  in  1  watchdog enable, level, driven by the low-voltage control FSM.
REQ-006 i_wdg_kick  in  1  single-cycle refresh pulse, generated on an SPI write to the watchdog refresh register.
REQ-007 i_reg_wdg_tmo_val  in  WDG_TICK_W  timeout, in ticks; 0 disables the timeout check.
REQ-008 i_reg_wdg_win_val  in  WDG_TICK_W  closed-window length, in ticks; 0 disables the early-kick check.
REQ-009 i_reg_wdg_err_clr  in  1  single-cycle write-1-clear of both error flags.
REQ-010 o_wdg_tmo_err  out  1  sticky timeout error, feeds the control FSM watchdog-timeout error input.
REQ-011 o_wdg_early_err  out  1  sticky early-kick error.
REQ-012 o_wdg_cur_st  out  2  current state encoding.
REQ-013 o_wdg_tick_cnt  out  WDG_TICK_W  current tick count.

Function
REQ-014 The block SHALL implement four states: WDG_IDLE, WDG_CLOSED, WDG_OPEN and WDG_ERR.
REQ-015 Prescaler behaviour:
- counts 0..PRESCL_DIV-1 while the state is CLOSED or OPEN;
- wraps to 0 after PRESCL_DIV-1 and asserts an internal tick for that cycle;
- holds at 0 in IDLE and ERR.
REQ-016 tick_cnt SHALL increment on each tick and saturate at all-ones.
REQ-017 Restart means prescaler=0 and tick_cnt=0, with next state CLOSED if win_val!=0, else OPEN.
REQ-018 In any state, i_wdg_scan_en=0 SHALL force IDLE on the next cycle and clear both counters. This has highest priority, including over a kick. Error flags are retained.
REQ-019 IDLE with i_wdg_scan_en=1 SHALL perform a restart.
REQ-020 CLOSED with a kick SHALL:
- go to ERR;
- set o_wdg_early_err.
REQ-021 CLOSED with no kick and tick_cnt>=win_val SHALL go to OPEN.
REQ-022 OPEN with a kick SHALL perform a restart.
REQ-023 CLOSED or OPEN with no kick, tmo_val!=0 and tick_cnt>=tmo_val SHALL:
- go to ERR;
- set o_wdg_tmo_err.
This has priority over REQ-021.
REQ-024 Kick and timeout condition in the same cycle in OPEN: the kick wins, giving a restart and no error.
REQ-025 ERR SHALL ignore kicks; i_reg_wdg_err_clr in ERR SHALL perform a restart.
REQ-026 i_reg_wdg_err_clr SHALL clear both flags in any state.
REQ-027 If an error is set in the same cycle as i_reg_wdg_err_clr, the set wins.
REQ-028 All outputs SHALL be registered; error flags assert one cycle after the triggering cycle.
REQ-029 Configuration values SHALL be sampled live every cycle. A changed value takes effect on the next comparison without a restart.
REQ-030 win_val>=tmo_val with tmo_val!=0: the timeout (REQ-023) fires before OPEN is reached, and every kick before then is early.

Reset
REQ-031 While i_rst_n=0, the following SHALL hold asynchronously:
- state=IDLE;
- prescaler=0 and o_wdg_tick_cnt=0;
- o_wdg_tmo_err=0 and o_wdg_early_err=0;
- o_wdg_cur_st=IDLE encoding.
REQ-032 Reset asserted mid-count SHALL discard all progress; after release the block behaves as at power-up.

Structure
REQ-033 The state encoding (2-bit), WDG_TICK_W and the PRESCL_DIV default SHALL live in the shared LV parameter include, beside the control FSM state constants.
REQ-034 The prescaler SHALL be a sub-module lv_wdg_prescl, with ports for enable, clear and tick output. The FSM and tick counter stay in lv_wdg_tmr.

Verification
Bench settings: PRESCL_DIV=4.
REQ-035 Scenario 1: en=1, win=2, tmo=5, kick at tick_cnt=3 -> state CLOSED->OPEN->CLOSED, tick_cnt=0, no error flag.
REQ-036 Scenario 2: en=1, win=2, tmo=5, kick at tick_cnt=1 -> ERR, o_wdg_early_err=1 one cycle later, o_wdg_tmo_err=0.
REQ-037 Scenario 3: en=1, win=0, tmo=3, no kick -> ERR after 12 cycles in OPEN, o_wdg_tmo_err=1, then err_clr -> both flags 0 and state OPEN with tick_cnt=0.
REQ-038 Scenario 4: kick in the same cycle tick_cnt reaches tmo=4 -> restart, o_wdg_tmo_err stays 0.
REQ-039 Scenario 5: en dropped to 0 in the same cycle as a kick while in OPEN -> IDLE, counters 0. A previously set tmo_err is retained.
REQ-040 Scenario 6: i_rst_n pulsed low at tick_cnt=3 with tmo_err=1 -> all outputs 0 and state IDLE immediately. Restarts from 0 on release.
